gcd_scheduler: RTL and testbench

Shares a single GCD compute core between `N` requesters. It arbitrates requests round-robin, latches the winner's operands and sequences the core through a start/done handshake. It returns the result tagged with the requester index. Operand pairs containing a zero are resolved locally without occupying the core, and a watchdog aborts a core that never reports done.

---
 rtl/gcd_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_gcd_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin front end sharing one GCD core among N requesters.
// Zero operands are answered locally; a watchdog aborts a core that stalls.
module gcd_scheduler #(
    parameter int  N       = 4,
    parameter int  W       = 16,
    parameter int  TIMEOUT = 1024,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N-1:0]    req_valid_i,
    output logic [N-1:0]    req_ready_o,
    input  logic [N*W-1:0]  req_a_i,
    input  logic [N*W-1:0]  req_b_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [ID_W-1:0] rsp_id_o,
    output logic [W-1:0]    rsp_gcd_o,
    output logic            rsp_err_o,
    output logic            core_start_o,
    output logic [W-1:0]    core_a_o,
    output logic [W-1:0]    core_b_o,
    output logic            core_abort_o,
    input  logic            core_done_i,
    input  logic [W-1:0]    core_result_i,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ID_W-1:0]  last_q;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     res_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             accept;
    logic             zero_op;
    logic             timeout_hit;

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((32'(last_q) + 32'(k)) % 32'(N));
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_a = req_a_i[32'(grant_idx) * W +: W];
        sel_b = req_b_i[32'(grant_idx) * W +: W];
    end

    assign accept      = (state_q == S_IDLE) && grant_found;
    assign zero_op     = (sel_a == '0) || (sel_b == '0);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = zero_op ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done_i || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so nothing is offered while reset is held.
    always_comb begin
        req_ready_o  = '0;
        core_start_o = 1'b0;
        core_abort_o = 1'b0;
        rsp_valid_o  = 1'b0;
        busy_o       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (grant_found && !reset_i) begin
                    req_ready_o[grant_idx] = 1'b1;
                end
            end
            S_ISSUE: begin
                core_start_o = 1'b1;
            end
            S_WAIT: begin
                core_abort_o = !core_done_i && timeout_hit;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= ID_LAST;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        last_q <= grant_idx;
                        id_q   <= grant_idx;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        if (zero_op) begin
                            res_q <= sel_a | sel_b;
                            err_q <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (core_done_i) begin
                        res_q <= core_result_i;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign rsp_id_o  = id_q;
    assign rsp_gcd_o = res_q;
    assign rsp_err_o = err_q;
    assign core_a_o  = a_q;
    assign core_b_o  = b_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed checks of arbitration, core sequencing,
// zero shortcut, watchdog, backpressure and reset for gcd_scheduler.
module tb_gcd_scheduler;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready_o;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid_o;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id_o;
    logic [W-1:0]    rsp_gcd_o;
    logic            rsp_err_o;
    logic            core_start_o;
    logic [W-1:0]    core_a_o;
    logic [W-1:0]    core_b_o;
    logic            core_abort_o;
    logic            core_done;
    logic [W-1:0]    core_result;
    logic            busy_o;

    int total  = 0;
    int passed = 0;
    int starts = 0;
    int aborts = 0;
    int s0;
    int a0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start_o) starts <= starts + 1;
        if (core_abort_o) aborts <= aborts + 1;
    end

    gcd_scheduler #(
        .N(N),
        .W(W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .req_a_i(req_a),
        .req_b_i(req_b),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id_o),
        .rsp_gcd_o(rsp_gcd_o),
        .rsp_err_o(rsp_err_o),
        .core_start_o(core_start_o),
        .core_a_o(core_a_o),
        .core_b_o(core_b_o),
        .core_abort_o(core_abort_o),
        .core_done_i(core_done),
        .core_result_i(core_result),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, 32'(req_ready_o), 0);
        chk({p, "_busy"}, 32'(busy_o), 0);
        chk({p, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        chk({p, "_rsp_id"}, 32'(rsp_id_o), 0);
        chk({p, "_rsp_gcd"}, 32'(rsp_gcd_o), 0);
        chk({p, "_rsp_err"}, 32'(rsp_err_o), 0);
        chk({p, "_start"}, 32'(core_start_o), 0);
        chk({p, "_abort"}, 32'(core_abort_o), 0);
        chk({p, "_core_a"}, 32'(core_a_o), 0);
        chk({p, "_core_b"}, 32'(core_b_o), 0);
    endtask

    initial begin
        reset_i     = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b0;
        core_done   = 1'b0;
        core_result = '0;
        cyc();
        cyc();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            set_ops(i, 16'(10 * (i + 1)), 16'(15 * (i + 1)));
        end
        #1;
        chk_zero("reset");

        // Fairness: every requester valid, grants rotate from 0.
        reset_i = 1'b0;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            #1;
            chk("fair_ready", 32'(req_ready_o), 32'(1 << g));
            cyc();
            #1;
            chk("fair_start", 32'(core_start_o), 1);
            chk("fair_core_a", 32'(core_a_o), 32'(10 * (g + 1)));
            cyc();
            core_done   = 1'b1;
            core_result = 16'(5 * (g + 1));
            cyc();
            core_done = 1'b0;
            #1;
            chk("fair_rsp_valid", 32'(rsp_valid_o), 1);
            chk("fair_rsp_id", 32'(rsp_id_o), 32'(g));
            chk("fair_rsp_gcd", 32'(rsp_gcd_o), 32'(5 * (g + 1)));
            chk("fair_rsp_ready_low", 32'(req_ready_o), 0);
            rsp_ready = 1'b1;
            if (n == 4) req_valid = '0;
            cyc();
            rsp_ready = 1'b0;
        end
        #1;
        chk("fair_idle_busy", 32'(busy_o), 0);

        // Single request from requester 2, core answers after 5 cycles.
        set_ops(2, 16'd12, 16'd18);
        req_valid = 4'b0100;
        s0 = starts;
        #1;
        chk("single_ready", 32'(req_ready_o), 32'b0100);
        cyc();
        req_valid = '0;
        #1;
        chk("single_start", 32'(core_start_o), 1);
        chk("single_core_a", 32'(core_a_o), 12);
        chk("single_core_b", 32'(core_b_o), 18);
        chk("single_busy", 32'(busy_o), 1);
        repeat (5) cyc();
        core_done   = 1'b1;
        core_result = 16'd6;
        #1;
        chk("single_no_early_rsp", 32'(rsp_valid_o), 0);
        cyc();
        core_done = 1'b0;
        #1;
        chk("single_rsp_valid", 32'(rsp_valid_o), 1);
        chk("single_rsp_id", 32'(rsp_id_o), 2);
        chk("single_rsp_gcd", 32'(rsp_gcd_o), 6);
        chk("single_rsp_err", 32'(rsp_err_o), 0);
        chk("single_one_start", 32'(starts), 32'(s0 + 1));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("single_rsp_drop", 32'(rsp_valid_o), 0);
        chk("single_idle", 32'(busy_o), 0);

        // Zero operands resolved without the core.
        s0 = starts;
        set_ops(1, 16'd0, 16'd35);
        req_valid = 4'b0010;
        #1;
        chk("zero1_ready", 32'(req_ready_o), 32'b0010);
        cyc();
        req_valid = '0;
        #1;
        chk("zero1_rsp_valid", 32'(rsp_valid_o), 1);
        chk("zero1_rsp_gcd", 32'(rsp_gcd_o), 35);
        chk("zero1_rsp_id", 32'(rsp_id_o), 1);
        chk("zero1_rsp_err", 32'(rsp_err_o), 0);
        chk("zero1_start", 32'(core_start_o), 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        set_ops(1, 16'd0, 16'd0);
        req_valid = 4'b0010;
        #1;
        chk("zero2_ready", 32'(req_ready_o), 32'b0010);
        cyc();
        req_valid = '0;
        #1;
        chk("zero2_rsp_valid", 32'(rsp_valid_o), 1);
        chk("zero2_rsp_gcd", 32'(rsp_gcd_o), 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("zero_no_start", 32'(starts), 32'(s0));

        // Watchdog: core never answers.
        a0 = aborts;
        set_ops(3, 16'd9, 16'd6);
        req_valid = 4'b1000;
        #1;
        chk("wd_ready", 32'(req_ready_o), 32'b1000);
        cyc();
        req_valid = '0;
        #1;
        chk("wd_start", 32'(core_start_o), 1);
        repeat (7) cyc();
        #1;
        chk("wd_abort_early", 32'(core_abort_o), 0);
        cyc();
        #1;
        chk("wd_abort", 32'(core_abort_o), 1);
        chk("wd_rsp_not_yet", 32'(rsp_valid_o), 0);
        cyc();
        #1;
        chk("wd_abort_single", 32'(core_abort_o), 0);
        chk("wd_rsp_valid", 32'(rsp_valid_o), 1);
        chk("wd_rsp_err", 32'(rsp_err_o), 1);
        chk("wd_rsp_gcd", 32'(rsp_gcd_o), 0);
        chk("wd_rsp_id", 32'(rsp_id_o), 3);
        chk("wd_abort_count", 32'(aborts), 32'(a0 + 1));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Done arrives in the timeout cycle: done wins.
        set_ops(0, 16'd8, 16'd12);
        req_valid = 4'b0001;
        #1;
        chk("col_ready", 32'(req_ready_o), 32'b0001);
        cyc();
        req_valid = '0;
        repeat (8) cyc();
        core_done   = 1'b1;
        core_result = 16'd4;
        #1;
        chk("col_no_abort", 32'(core_abort_o), 0);
        cyc();
        core_done = 1'b0;
        #1;
        chk("col_rsp_valid", 32'(rsp_valid_o), 1);
        chk("col_rsp_gcd", 32'(rsp_gcd_o), 4);
        chk("col_rsp_err", 32'(rsp_err_o), 0);
        chk("col_abort_count", 32'(aborts), 32'(a0 + 1));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // Backpressure: response held 20 cycles while others wait.
        set_ops(1, 16'd21, 16'd14);
        req_valid = 4'b0010;
        #1;
        chk("bp_ready", 32'(req_ready_o), 32'b0010);
        cyc();
        req_valid = 4'b1101;
        #1;
        chk("bp_start", 32'(core_start_o), 1);
        chk("bp_core_a", 32'(core_a_o), 21);
        cyc();
        core_done   = 1'b1;
        core_result = 16'd7;
        cyc();
        core_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("bp_hold_valid", 32'(rsp_valid_o), 1);
            chk("bp_hold_gcd", 32'(rsp_gcd_o), 7);
            chk("bp_hold_id", 32'(rsp_id_o), 1);
            chk("bp_hold_ready", 32'(req_ready_o), 0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 32'(rsp_valid_o), 1);
        chk("bp_hs_no_accept", 32'(req_ready_o), 0);
        cyc();
        rsp_ready = 1'b0;
        #1;
        chk("bp_resume_ready", 32'(req_ready_o), 32'b0100);
        chk("bp_resume_idle", 32'(busy_o), 0);
        cyc();
        req_valid = '0;
        #1;
        chk("rst_pre_start", 32'(core_start_o), 1);
        chk("rst_pre_core_a", 32'(core_a_o), 12);

        // Reset in WAIT clears everything and the pointer.
        cyc();
        cyc();
        reset_i   = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk_zero("midreset");
        cyc();
        reset_i = 1'b0;
        #1;
        chk("midreset_no_abort", 32'(aborts), 32'(a0 + 1));
        chk("midreset_prio", 32'(req_ready_o), 32'b0001);
        cyc();
        req_valid = '0;
        #1;
        chk("post_start", 32'(core_start_o), 1);
        chk("post_core_a", 32'(core_a_o), 8);
        cyc();
        core_done   = 1'b1;
        core_result = 16'd4;
        cyc();
        core_done = 1'b0;
        #1;
        chk("post_rsp_id", 32'(rsp_id_o), 0);
        chk("post_rsp_gcd", 32'(rsp_gcd_o), 4);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
